ofifo_psum: RTL and testbench

Per-column output FIFO bank for the systolic MAC array. It sits directly downstream of the `mac_col` chain. Each column pushes its 32-bit partial sum into its own lane whenever that column asserts `fifo_wr`. Because the chain delays each column by one cycle, the lanes fill with a skew; the bank re-aligns the results and presents one complete row (all columns) to the readout logic only once every lane holds data.

---
 rtl/ofifo_psum.sv | 97 +++++++++
 tb/tb_ofifo_psum.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ofifo_psum.sv
// Per-column output FIFO bank: skewed per-lane writes, row-aligned show-ahead reads.
// Optional sticky dropped-write flag enabled by defining OFIFO_OVERFLOW_EN.
module ofifo_psum #(
  parameter int col     = 8,
  parameter int bw_psum = 32,
  parameter int depth   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [col*bw_psum-1:0]   in,
  input  logic [col-1:0]           wr,
  input  logic                     rd,
  output logic [col*bw_psum-1:0]   out,
  output logic                     o_valid,
  output logic                     o_full,
  output logic                     o_ready,
  output logic                     overflow
);

  localparam int AW = $clog2(depth);

  typedef logic [AW:0] ptr_t;

  // All lanes pop together, so a single shared read pointer serves every lane.
  ptr_t               r_wptr [col];
  ptr_t               r_rptr;
  logic [bw_psum-1:0] r_mem  [col][depth];

  logic [col-1:0] w_full;
  logic [col-1:0] w_empty;
  logic [col-1:0] w_push;
  logic           w_pop;

  always_comb begin
    w_full  = '0;
    w_empty = '0;
    w_push  = '0;
    for (int unsigned i = 0; i < col; i++) begin
      w_full[i]  = (r_wptr[i][AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[i][AW] != r_rptr[AW]);
      w_empty[i] = (r_wptr[i] == r_rptr);
      w_push[i]  = wr[i] && !w_full[i];
    end
  end

  assign o_valid = ~|w_empty;
  assign o_full  = |w_full;
  assign o_ready = ~o_full;
  assign w_pop   = rd && o_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < col; i++) begin
        r_wptr[i] <= '0;
      end
      r_rptr <= '0;
    end else begin
      for (int unsigned i = 0; i < col; i++) begin
        if (w_push[i]) begin
          r_wptr[i] <= r_wptr[i] + 1'b1;
        end
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

  // Storage is never reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < col; i++) begin
      if (w_push[i]) begin
        r_mem[i][r_wptr[i][AW-1:0]] <= in[i*bw_psum +: bw_psum];
      end
    end
  end

  for (genvar g = 0; g < col; g++) begin : g_lane
    assign out[g*bw_psum +: bw_psum] = r_mem[g][r_rptr[AW-1:0]];
  end

`ifdef OFIFO_OVERFLOW_EN
  logic r_overflow;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
    end else if (|(wr & w_full)) begin
      r_overflow <= 1'b1;
    end
  end

  assign overflow = r_overflow;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_ofifo_psum.sv
// Self-checking bench for ofifo_psum: per-lane queue scoreboard plus a vector table for skewed fill.
module tb_ofifo_psum;

  localparam int COL = 8;
  localparam int BW  = 32;
  localparam int DEP = 16;

  logic                clk;
  logic                reset_n;
  logic [COL*BW-1:0]   din;
  logic [COL-1:0]      wr;
  logic                rd;
  logic [COL*BW-1:0]   dout;
  logic                o_valid;
  logic                o_full;
  logic                o_ready;
  logic                ovf;

  int checks = 0;
  int errors = 0;

  logic [BW-1:0] q [COL][$];
  logic          exp_ovf;

  ofifo_psum #(.col(COL), .bw_psum(BW), .depth(DEP)) dut (
    .clk      (clk),
    .reset    (reset_n),
    .in       (din),
    .wr       (wr),
    .rd       (rd),
    .out      (dout),
    .o_valid  (o_valid),
    .o_full   (o_full),
    .o_ready  (o_ready),
    .overflow (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [COL*BW-1:0] mkrow(input int base, input int stride);
    logic [COL*BW-1:0] r;
    r = '0;
    for (int i = 0; i < COL; i++) r[i*BW +: BW] = BW'(base + stride*i);
    return r;
  endfunction

  task automatic check_state(input string tag);
    logic ev;
    logic ef;
    ev = 1'b1;
    ef = 1'b0;
    for (int i = 0; i < COL; i++) begin
      if (q[i].size() == 0)   ev = 1'b0;
      if (q[i].size() == DEP) ef = 1'b1;
    end
    chk({tag, "_valid"}, 64'(o_valid), 64'(ev));
    chk({tag, "_full"},  64'(o_full),  64'(ef));
    chk({tag, "_ready"}, 64'(o_ready), 64'(!ef));
    chk({tag, "_ovf"},   64'(ovf),     64'(exp_ovf));
    if (ev) begin
      for (int i = 0; i < COL; i++) chk({tag, "_head"}, 64'(dout[i*BW +: BW]), 64'(q[i][0]));
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < COL; i++) q[i].delete();
    exp_ovf = 1'b0;
  endtask

  // One clock: drive, compare popped row against the scoreboard, update model, re-check.
  task automatic step(input logic [COL-1:0] w, input logic [COL*BW-1:0] d, input logic r);
    logic         allne;
    logic         pop;
    logic [COL-1:0] full;
    wr  = w;
    din = d;
    rd  = r;
    allne = 1'b1;
    for (int i = 0; i < COL; i++) begin
      if (q[i].size() == 0) allne = 1'b0;
      full[i] = (q[i].size() == DEP);
    end
    pop = r && allne;
    if (pop) begin
      for (int i = 0; i < COL; i++) chk("pop_lane", 64'(dout[i*BW +: BW]), 64'(q[i][0]));
    end
`ifdef OFIFO_OVERFLOW_EN
    if (|(w & full)) exp_ovf = 1'b1;
`endif
    @(posedge clk);
    if (pop) begin
      for (int i = 0; i < COL; i++) void'(q[i].pop_front());
    end
    for (int i = 0; i < COL; i++) begin
      if (w[i] && !full[i]) q[i].push_back(d[i*BW +: BW]);
    end
    #1;
    wr = '0;
    rd = 1'b0;
    check_state("step");
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_clear();
    check_state("reset");
    #5;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [COL-1:0]    w;
    logic              r;
    logic [COL*BW-1:0] d;
    logic              ev;
    logic              ef;
  } vec_t;

  vec_t tbl [11];

  initial begin
    reset_n = 1'b0;
    din     = '0;
    wr      = '0;
    rd      = 1'b0;
    model_clear();

    // Skewed fill table: lane i writes 100+i at cycle i, 200+i at cycle i+1, then two pops.
    for (int c = 0; c < 11; c++) begin
      tbl[c].w  = '0;
      tbl[c].d  = '0;
      tbl[c].r  = (c >= 9);
      tbl[c].ev = (c >= 7) && (c <= 9);
      tbl[c].ef = 1'b0;
      for (int i = 0; i < COL; i++) begin
        if (c == i) begin
          tbl[c].w[i] = 1'b1;
          tbl[c].d[i*BW +: BW] = BW'(100 + i);
        end else if (c == i + 1) begin
          tbl[c].w[i] = 1'b1;
          tbl[c].d[i*BW +: BW] = BW'(200 + i);
        end
      end
    end

    #1;
    check_state("rst_hold");
    #11;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Idle pop after reset must not move pointers.
    step('0, '0, 1'b1);
    chk("idle_valid", 64'(o_valid), 64'd0);
    chk("idle_ready", 64'(o_ready), 64'd1);

    for (int c = 0; c < 11; c++) begin
      step(tbl[c].w, tbl[c].d, tbl[c].r);
      chk("tbl_valid", 64'(o_valid), 64'(tbl[c].ev));
      chk("tbl_full",  64'(o_full),  64'(tbl[c].ef));
      if (c == 7) chk("tbl_lane7", 64'(dout[7*BW +: BW]), 64'd107);
      if (c == 9) chk("tbl_lane3", 64'(dout[3*BW +: BW]), 64'd203);
    end

    // Lane 0 alone to full, then a dropped write of 99.
    for (int k = 0; k < DEP; k++) step(8'h01, mkrow(k, 0), 1'b0);
    chk("l0_full",  64'(o_full),  64'd1);
    chk("l0_ready", 64'(o_ready), 64'd0);
    chk("l0_valid", 64'(o_valid), 64'd0);
    step(8'h01, mkrow(99, 0), 1'b0);
`ifdef OFIFO_OVERFLOW_EN
    chk("l0_ovf", 64'(ovf), 64'd1);
`else
    chk("l0_ovf", 64'(ovf), 64'd0);
`endif

    // Remaining lanes to full, then write-all with pop: writes dropped, one row popped.
    for (int k = 0; k < DEP; k++) step(8'hFE, mkrow(k, 256), 1'b0);
    chk("all_full", 64'(o_full), 64'd1);
    step(8'hFF, mkrow(32'h0DEAD, 0), 1'b1);
    chk("full_after_pop", 64'(o_full), 64'd0);
    chk("lane0_after_pop", 64'(dout[0 +: BW]), 64'd1);
    for (int k = 0; k < DEP - 1; k++) step('0, '0, 1'b1);
    chk("drained_valid", 64'(o_valid), 64'd0);

    // Wrap-around: constant occupancy of one row over 40 push+pop cycles.
    do_reset();
    step(8'hFF, mkrow(0, 1), 1'b0);
    for (int k = 1; k <= 40; k++) begin
      step(8'hFF, mkrow(k*COL, 1), 1'b1);
      chk("wrap_valid", 64'(o_valid), 64'd1);
      chk("wrap_lane5", 64'(dout[5*BW +: BW]), 64'(k*COL + 5));
    end

    // Asynchronous reset mid-fill.
    do_reset();
    for (int k = 0; k < 3; k++) step(8'hFF, mkrow(50 + k*COL, 1), 1'b0);
    chk("pre_rst_valid", 64'(o_valid), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    model_clear();
    chk("async_valid", 64'(o_valid), 64'd0);
    chk("async_full",  64'(o_full),  64'd0);
    chk("async_ready", 64'(o_ready), 64'd1);
    chk("async_ovf",   64'(ovf),     64'd0);
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    step(8'hFF, mkrow(7, 1), 1'b0);
    chk("fresh_lane7", 64'(dout[7*BW +: BW]), 64'd14);
    step('0, '0, 1'b1);
    chk("fresh_empty", 64'(o_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
